// File: rtl/ddr_pkg.sv
// Shared definitions for the MCB command-port logic: instruction codes,
// arbiter state encoding and the burst stride helper.
package ddr_pkg;

  localparam logic [2:0] MCB_INSTR_WR = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD = 3'b001;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_t;

  // Bytes covered by one burst of 32-bit words.
  function automatic int unsigned burst_stride(input int unsigned words);
    return words * 4;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter.sv
// Shares one MCB command port between capture writes and USB readback reads,
// and walks capture write addresses around a ring buffer.
module ddr_port_arbiter
  import ddr_pkg::*;
#(
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned BURST_WORDS = 64,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RING_BYTES  = 32'h0100_0000
) (
  input  logic              ddr_usrclk,
  input  logic              ddr_usrreset_n,
  input  logic              cap_clear,
  input  logic              wr_req,
  output logic              wr_grant,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic              cmd_full,
  output logic [ADDR_W-1:0] wr_next_addr,
  output logic              wrapped,
  output logic [31:0]       wr_burst_count,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   STRIDE_X  = (ADDR_W+1)'(burst_stride(BURST_WORDS));
  localparam logic [ADDR_W:0]   RING_END  = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(RING_BYTES);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  arb_state_t        state;
  logic              last_rd;
  logic              win_wr;
  logic [ADDR_W:0]   wr_addr_inc;

  // Round-robin: with both requests up, write wins unless it won last time.
  assign win_wr      = wr_req && (!rd_req || last_rd);
  assign wr_addr_inc = {1'b0, wr_next_addr} + STRIDE_X;
  assign cmd_bl      = 6'(BURST_WORDS - 1);

  always_ff @(posedge ddr_usrclk or negedge ddr_usrreset_n) begin
    if (!ddr_usrreset_n) begin
      state          <= ARB_IDLE;
      last_rd        <= 1'b1;
      cmd_en         <= 1'b0;
      wr_grant       <= 1'b0;
      rd_grant       <= 1'b0;
      busy           <= 1'b0;
      cmd_instr      <= MCB_INSTR_WR;
      cmd_byte_addr  <= '0;
      wr_next_addr   <= BASE;
      wrapped        <= 1'b0;
      wr_burst_count <= '0;
    end else begin
      cmd_en   <= 1'b0;
      wr_grant <= 1'b0;
      rd_grant <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (!cmd_full && (wr_req || rd_req)) begin
            cmd_en <= 1'b1;
            busy   <= 1'b1;
            state  <= ARB_ISSUE;
            if (win_wr) begin
              wr_grant       <= 1'b1;
              last_rd        <= 1'b0;
              cmd_instr      <= MCB_INSTR_WR;
              cmd_byte_addr  <= wr_next_addr;
              wr_burst_count <= wr_burst_count + 32'd1;
              if (wr_addr_inc == RING_END) begin
                wr_next_addr <= BASE;
                wrapped      <= 1'b1;
              end else begin
                wr_next_addr <= wr_addr_inc[ADDR_W-1:0];
              end
            end else begin
              rd_grant      <= 1'b1;
              last_rd       <= 1'b1;
              cmd_instr     <= MCB_INSTR_RD;
              cmd_byte_addr <= rd_addr & WORD_MASK;
            end
          end
        end
        ARB_ISSUE: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
      // A clear overrides any same-cycle write update of the ring registers.
      if (cap_clear) begin
        wr_next_addr   <= BASE;
        wrapped        <= 1'b0;
        wr_burst_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Randomized and directed bench for ddr_port_arbiter against a behavioural
// model that tracks bursts-since-clear and derives ring addresses from it.
module tb_ddr_port_arbiter;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned BWORDS = 64;
  localparam int unsigned BASE   = 0;
  localparam int unsigned RING   = 32'h400;
  localparam longint      STRIDE = BWORDS * 4;
  localparam longint      NB     = RING / (BWORDS * 4);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cap_clear = 1'b0;
  logic              wr_req = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              cmd_full = 1'b0;
  logic              wr_grant, rd_grant, cmd_en, wrapped, busy;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [ADDR_W-1:0] cmd_byte_addr, wr_next_addr;
  logic [31:0]       wr_burst_count;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_port_arbiter #(
    .ADDR_W(ADDR_W), .BURST_WORDS(BWORDS), .BASE_ADDR(BASE), .RING_BYTES(RING)
  ) dut (
    .ddr_usrclk(clk), .ddr_usrreset_n(rst_n), .cap_clear(cap_clear),
    .wr_req(wr_req), .wr_grant(wr_grant), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_grant(rd_grant), .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .wr_next_addr(wr_next_addr),
    .wrapped(wrapped), .wr_burst_count(wr_burst_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the ring is described by the number of bursts since clear.
  longint      m_n = 0;
  bit          m_gap = 0;
  bit          m_last_rd = 1;
  bit          e_en = 0, e_wg = 0, e_rg = 0;
  logic [2:0]  e_instr = 3'b000;
  logic [ADDR_W-1:0] e_addr = '0;

  function automatic logic [ADDR_W-1:0] ring_addr(input longint n);
    return ADDR_W'(longint'(BASE) + (n % NB) * STRIDE);
  endfunction

  task automatic model_step();
    bit take_wr;
    if (!rst_n) begin
      m_n = 0; m_gap = 0; m_last_rd = 1;
      e_en = 0; e_wg = 0; e_rg = 0; e_instr = 3'b000; e_addr = '0;
    end else begin
      e_en = 0; e_wg = 0; e_rg = 0;
      if (!m_gap && !cmd_full && (wr_req || rd_req)) begin
        take_wr = wr_req && !(rd_req && !m_last_rd);
        if (take_wr) begin
          e_addr = ring_addr(m_n); e_instr = 3'b000; e_wg = 1; m_last_rd = 0; m_n++;
        end else begin
          e_addr = ADDR_W'((longint'(rd_addr) / 4) * 4); e_instr = 3'b001; e_rg = 1; m_last_rd = 1;
        end
        e_en = 1; m_gap = 1;
      end else begin
        m_gap = 0;
      end
      if (cap_clear) m_n = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    chk("cmd_en", cmd_en, e_en);
    chk("wr_grant", wr_grant, e_wg);
    chk("rd_grant", rd_grant, e_rg);
    chk("busy", busy, m_gap);
    chk("cmd_instr", cmd_instr, e_instr);
    chk("cmd_byte_addr", cmd_byte_addr, e_addr);
    chk("wr_next_addr", wr_next_addr, ring_addr(m_n));
    chk("wrapped", wrapped, m_n >= NB);
    chk("wr_burst_count", wr_burst_count, 32'(m_n));
    chk("cmd_bl", cmd_bl, 6'd63);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grant(output logic g_wr, output logic [ADDR_W-1:0] a,
                            output logic [2:0] ins, output time t);
    g_wr = 0; a = '0; ins = '0; t = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (wr_grant || rd_grant) begin
        g_wr = wr_grant; a = cmd_byte_addr; ins = cmd_instr; t = $time;
        return;
      end
    end
    chk("grant_timeout", 1, 0);
  endtask

  initial begin
    logic              g_wr;
    logic [ADDR_W-1:0] a;
    logic [2:0]        ins;
    time               t, tprev;

    // Reset values
    repeat (3) tick();
    chk("rst_cmd_en", cmd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_next_addr", wr_next_addr, 30'h0);
    chk("rst_count", wr_burst_count, 0);
    chk("rst_addr", cmd_byte_addr, 0);
    rst_n = 1'b1;
    tick();

    // Write only: four grants, one every two cycles, then the wrap
    wr_req = 1'b1;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g_wr, a, ins, t);
      chk($sformatf("wo_addr%0d", i), a, 64'(i * 256));
      chk($sformatf("wo_instr%0d", i), ins, 3'b000);
      chk($sformatf("wo_isw%0d", i), g_wr, 1);
      if (i > 0) chk($sformatf("wo_spacing%0d", i), t - tprev, 20);
      tprev = t;
    end
    wr_req = 1'b0;
    tick();
    chk("wo_count4", wr_burst_count, 4);
    chk("wrap_flag4", wrapped, 1);
    chk("wrap_next4", wr_next_addr, 30'h0);
    wr_req = 1'b1;
    wait_grant(g_wr, a, ins, t);
    wr_req = 1'b0;
    chk("wrap_addr5", a, 30'h000);
    tick();
    chk("wrap_next5", wr_next_addr, 30'h100);
    chk("wrap_count5", wr_burst_count, 5);

    // Clear colliding with a write grant at 0x300
    cap_clear = 1'b1; tick(); cap_clear = 1'b0;
    chk("clr_count", wr_burst_count, 0);
    chk("clr_wrapped", wrapped, 0);
    wr_req = 1'b1;
    for (int i = 0; i < 3; i++) wait_grant(g_wr, a, ins, t);
    tick();
    cap_clear = 1'b1;
    tick();
    cap_clear = 1'b0; wr_req = 1'b0;
    chk("coll_grant", wr_grant, 1);
    chk("coll_addr", cmd_byte_addr, 30'h300);
    chk("coll_next", wr_next_addr, 30'h0);
    chk("coll_count", wr_burst_count, 0);
    chk("coll_wrapped", wrapped, 0);

    // Contention after reset: W, R, W, R with word-aligned read addresses
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    rd_addr = 30'h1234; wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g_wr, a, ins, t);
      chk($sformatf("ct_winner%0d", i), g_wr, (i % 2) == 0);
      if (i % 2 == 1) begin
        chk($sformatf("ct_raddr%0d", i), a, 30'h1234);
        chk($sformatf("ct_rinstr%0d", i), ins, 3'b001);
        rd_addr = 30'h1237;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) tick();

    // Backpressure
    cmd_full = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_noen%0d", i), cmd_en, 0);
    end
    cmd_full = 1'b0;
    tick();
    chk("bp_first_en", cmd_en, 1);
    chk("bp_first_wr", wr_grant, 1);

    // Asynchronous reset while in ISSUE
    #1 rst_n = 1'b0;
    #1;
    chk("ar_cmd_en", cmd_en, 0);
    chk("ar_wr_grant", wr_grant, 0);
    chk("ar_busy", busy, 0);
    chk("ar_next", wr_next_addr, 30'h0);
    wr_req = 1'b0; rd_req = 1'b0;
    tick(); rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      wr_req    = $urandom_range(0, 3) != 0;
      rd_req    = $urandom_range(0, 3) != 0;
      cmd_full  = $urandom_range(0, 5) == 0;
      cap_clear = $urandom_range(0, 40) == 0;
      rd_addr   = ADDR_W'($urandom);
      rst_n     = $urandom_range(0, 499) != 0;
    end
    tick();
    wr_req = 1'b0; rd_req = 1'b0; cmd_full = 1'b0; cap_clear = 1'b0; rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
